// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared funct codes, FSM state type and iteration count for ex_muldiv
package muldiv_pkg;

  localparam int ITER = 32;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_div_core.sv
// rtl/muldiv_div_core.sv - restoring divider on unsigned magnitudes, one quotient bit per step
module muldiv_div_core #(
  parameter int NBITS = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             load,
  input  logic             step,
  input  logic [NBITS-1:0] dividend,
  input  logic [NBITS-1:0] divisor,
  output logic [NBITS-1:0] quotient,
  output logic [NBITS-1:0] remainder
);

  logic [NBITS-1:0] quo;
  logic [NBITS-1:0] rem;
  logic [NBITS-1:0] dvsr;
  logic [NBITS:0]   shifted;
  logic             fits;
  logic [NBITS-1:0] sub;

  // Partial remainder shifted left with the next dividend bit; the true
  // difference is always below the divisor, so its low bits are exact.
  assign shifted = {rem, quo[NBITS-1]};
  assign fits    = shifted >= {1'b0, dvsr};
  assign sub     = shifted[NBITS-1:0] - dvsr;

  // Load operands on accept, then one restoring-subtract step per cycle
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      quo  <= '0;
      rem  <= '0;
      dvsr <= '0;
    end else if (load) begin
      quo  <= dividend;
      rem  <= '0;
      dvsr <= divisor;
    end else if (step) begin
      rem  <= fits ? sub : shifted[NBITS-1:0];
      quo  <= {quo[NBITS-2:0], fits};
    end
  end

  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - EX-stage iterative HI/LO multiply/divide unit; MULDIV_DIVIDER_EN enables DIV/DIVU
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int NBITS = 32,
  parameter int FBITS = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_rtype,
  input  logic [FBITS-1:0] i_funct,
  input  logic [NBITS-1:0] i_rs_data,
  input  logic [NBITS-1:0] i_rt_data,
  output logic             o_stall,
  output logic [NBITS-1:0] o_mf_data,
  output logic [NBITS-1:0] o_hi,
  output logic [NBITS-1:0] o_lo,
  output logic             o_div_by_zero
);

  localparam logic [5:0] CNT_LAST = 6'(ITER - 1);

  function automatic logic [NBITS-1:0] mag(input logic [NBITS-1:0] v, input logic sgn);
    return (sgn && v[NBITS-1]) ? -v : v;
  endfunction

  state_t             state, state_next;
  logic [5:0]         cnt;
  logic [NBITS-1:0]   mcand;
  logic [2*NBITS-1:0] prod;
  logic [NBITS:0]     mul_sum;
  logic [NBITS-1:0]   hi, lo;
  logic               neg_res, dbz_q;
  logic               dec_en, sgn_op, is_mul;
  logic               acc_mul, acc_div, acc_dbz;
  logic               step_mul, step_div, wr_res, wr_hi, wr_lo;

  assign dec_en = i_valid & i_rtype;
  assign is_mul = dec_en & ((i_funct == FBITS'(F_MULT)) | (i_funct == FBITS'(F_MULTU)));
  assign sgn_op = (i_funct == FBITS'(F_MULT)) | (i_funct == FBITS'(F_DIV));
  assign acc_mul = (state == S_IDLE) & is_mul;

`ifdef MULDIV_DIVIDER_EN
  logic             is_div, rt_zero, neg_rem, is_div_q;
  logic [NBITS-1:0] quotient, remainder;
  assign is_div  = dec_en & ((i_funct == FBITS'(F_DIV)) | (i_funct == FBITS'(F_DIVU)));
  assign rt_zero = (i_rt_data == '0);
  assign acc_div = (state == S_IDLE) & is_div & ~rt_zero;
  assign acc_dbz = (state == S_IDLE) & is_div & rt_zero;

  muldiv_div_core #(.NBITS(NBITS)) u_div (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .load      (acc_div),
    .step      (step_div),
    .dividend  (mag(i_rs_data, sgn_op)),
    .divisor   (mag(i_rt_data, sgn_op)),
    .quotient  (quotient),
    .remainder (remainder)
  );
  assign o_div_by_zero = dbz_q;
`else
  assign acc_div       = 1'b0;
  assign acc_dbz       = 1'b0;
  assign o_div_by_zero = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic: only IDLE accepts, MUL/DIV run ITER steps, DONE retires
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (acc_mul)      state_next = S_MUL;
        else if (acc_div) state_next = S_DIV;
        else if (acc_dbz) state_next = S_DONE;
      end
      S_MUL, S_DIV: if (cnt == CNT_LAST) state_next = S_DONE;
      S_DONE:       state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  // Outputs: stall covers the accept cycle and the iterations, never DONE
  always_comb begin
    o_stall  = 1'b0;
    step_mul = 1'b0;
    step_div = 1'b0;
    wr_res   = 1'b0;
    wr_hi    = 1'b0;
    wr_lo    = 1'b0;
    case (state)
      S_IDLE: begin
        o_stall = i_rst & (acc_mul | acc_div | acc_dbz);
        wr_hi   = dec_en & (i_funct == FBITS'(F_MTHI));
        wr_lo   = dec_en & (i_funct == FBITS'(F_MTLO));
      end
      S_MUL:   begin o_stall = i_rst; step_mul = 1'b1; end
      S_DIV:   begin o_stall = i_rst; step_div = 1'b1; end
      S_DONE:  wr_res = ~dbz_q;
      default: o_stall = 1'b0;
    endcase
  end

  // Shift-add step: conditionally add multiplicand to the upper half, shift right
  assign mul_sum = {1'b0, prod[2*NBITS-1:NBITS]} + (prod[0] ? {1'b0, mcand} : '0);

  // Operand latch, iteration counter and multiplier accumulator
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt     <= '0;
      mcand   <= '0;
      prod    <= '0;
      neg_res <= 1'b0;
      dbz_q   <= 1'b0;
`ifdef MULDIV_DIVIDER_EN
      neg_rem  <= 1'b0;
      is_div_q <= 1'b0;
`endif
    end else begin
      dbz_q <= acc_dbz;
      if (acc_mul || acc_div) begin
        cnt     <= '0;
        neg_res <= sgn_op & (i_rs_data[NBITS-1] ^ i_rt_data[NBITS-1]);
`ifdef MULDIV_DIVIDER_EN
        neg_rem  <= sgn_op & i_rs_data[NBITS-1];
        is_div_q <= acc_div;
`endif
      end else if (step_mul || step_div) begin
        cnt <= cnt + 6'd1;
      end
      if (acc_mul) begin
        mcand <= mag(i_rs_data, sgn_op);
        prod  <= {{NBITS{1'b0}}, mag(i_rt_data, sgn_op)};
      end else if (step_mul) begin
        prod  <= {mul_sum, prod[NBITS-1:1]};
      end
    end
  end

  // Architectural HI/LO: signed results applied at DONE, or moves from rs
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      hi <= '0;
      lo <= '0;
    end else if (wr_res) begin
`ifdef MULDIV_DIVIDER_EN
      if (is_div_q) begin
        lo <= neg_res ? -quotient : quotient;
        hi <= neg_rem ? -remainder : remainder;
      end else begin
        {hi, lo} <= neg_res ? -prod : prod;
      end
`else
      {hi, lo} <= neg_res ? -prod : prod;
`endif
    end else begin
      if (wr_hi) hi <= i_rs_data;
      if (wr_lo) lo <= i_rs_data;
    end
  end

  assign o_hi = hi;
  assign o_lo = lo;
  assign o_mf_data = (dec_en && i_funct == FBITS'(F_MFHI)) ? hi :
                     (dec_en && i_funct == FBITS'(F_MFLO)) ? lo : '0;

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter NBITS, 32, data width of operands, HI, LO and the move-from result.
REQ-002 Parameter FBITS, 6, width of the funct field.
REQ-003 Port i_clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 Port i_rst, input, 1, synchronous, active-low reset.
REQ-005 Port i_valid, input, 1, a valid instruction occupies EX (low for a bubble).
REQ-006 Port i_rtype, input, 1, the EX instruction is R-type (aluop decoded upstream).
REQ-007 Port i_funct, input, FBITS, funct field of the EX instruction.
REQ-008 Port i_rs_data, input, NBITS, rs operand after forwarding.
REQ-009 Port i_rt_data, input, NBITS, rt operand after forwarding.
REQ-010 Port o_stall, output, 1, freeze PC, IF/ID and ID/EX; insert a bubble into EX/MEM.
REQ-011 Port o_mf_data, output, NBITS, HI for MFHI, LO for MFLO, zero otherwise.
REQ-012 Port o_hi and o_lo, output, NBITS each, architectural HI/LO registers.
REQ-013 Port o_div_by_zero, output, 1, one-cycle flag for a divide with rt = 0.

Function
REQ-014 Decode SHALL occur only when i_valid and i_rtype are both high. Funct codes: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B. All other codes are ignored.
REQ-015 FSM states SHALL be IDLE, MUL, DIV and DONE. Only IDLE accepts new operations.
REQ-016 Accepting MULT/MULTU in IDLE SHALL latch both operands, clear the 6-bit counter and go to MUL.
- DIV/DIVU with rt != 0 SHALL do the same but go to DIV.
REQ-017 MUL and DIV SHALL each run one shift-add or restoring-subtract step per cycle for exactly 32 cycles, then go to DONE.
REQ-018 DONE SHALL write HI/LO at its closing edge and then return to IDLE.
REQ-019 o_stall SHALL be combinational: high in the accept cycle and throughout MUL/DIV, low in DONE and IDLE.
- Result: 33 stall cycles; the instruction leaves EX during DONE; HI/LO are visible from the following cycle.
REQ-020 Signed operations SHALL iterate on magnitudes and apply signs in DONE.
- Product sign = XOR of operand signs.
- Quotient sign = XOR of operand signs; remainder sign = dividend sign.
REQ-021 Results: MULT/MULTU {HI,LO} = full 64-bit product; DIV/DIVU LO = quotient, HI = remainder.
- DIV 0x80000000 / 0xFFFFFFFF SHALL give LO = 0x80000000, HI = 0.
REQ-022 DIV/DIVU with rt = 0 SHALL go straight to DONE.
- HI/LO unchanged; o_div_by_zero high during DONE; o_stall high for the accept cycle only.
REQ-023 MTHI/MTLO in IDLE SHALL write rs to HI/LO at the next edge, with no stall.
REQ-024 MFHI/MFLO SHALL drive o_mf_data combinationally, with no stall.

Reset
REQ-025 When i_rst = 0 at a rising edge: state IDLE, HI = LO = 0, counter and operand registers cleared, o_div_by_zero = 0.
- o_stall SHALL be 0 while reset is asserted.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no HI/LO write and no flag.

Configuration
REQ-027 Macro MULDIV_DIVIDER_EN defined: DIV/DIVU SHALL behave as specified above.
REQ-028 Macro MULDIV_DIVIDER_EN undefined: no divide logic; DIV/DIVU SHALL be ignored (no stall, HI/LO unchanged, o_div_by_zero tied 0).

Structure
REQ-029 Shared package muldiv_pkg SHALL hold: funct code constants, the FSM state typedef, and ITER = 32.
REQ-030 The restoring divider SHALL be a sub-module muldiv_div_core, instantiated only under MULDIV_DIVIDER_EN.

Verification
REQ-031 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> o_stall high for 33 cycles; then HI = 0xFFFFFFFE, LO = 0x00000001.
REQ-032 MULT 0xFFFFFFFD x 0x00000005 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFF1; next-cycle MFLO gives o_mf_data = 0xFFFFFFF1.
REQ-033 DIV 0xFFFFFFF9 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; DIVU 100 / 7 -> LO = 0x0E, HI = 0x02.
REQ-034 DIVU x / 0 with HI = LO = 0x1234 -> single stall cycle; o_div_by_zero pulse; HI/LO stay 0x1234.
REQ-035 MULT started, i_rst low at iteration 10 -> IDLE next cycle, o_stall = 0, HI = LO = 0.
REQ-036 MTHI 0xA5A5A5A5 then MFHI -> no stall; o_mf_data = 0xA5A5A5A5.
